// File: rtl/dmem_wb_arbiter_if.sv
// Bus bundle for the data-memory arbiter: core port, Wishbone slave port and shared SRAM port.
// Core: request accepted in a cycle with core_ce_n=0 and core_stall=0; Wishbone: cyc&stb held until the one-cycle ack.
interface dmem_wb_arbiter_if #(
  parameter int BANKS = 2
);
  localparam int AW = 9 + $clog2(BANKS);

  logic                   core_ce_n;
  logic                   core_we_n;
  logic [3:0]             core_wm;
  logic [AW-1:0]          core_addr;
  logic [31:0]            core_wdata;
  logic [31:0]            core_rdata;
  logic                   core_stall;

  logic                   wbs_cyc_i;
  logic                   wbs_stb_i;
  logic                   wbs_we_i;
  logic [3:0]             wbs_sel_i;
  logic [31:0]            wbs_adr_i;
  logic [31:0]            wbs_dat_i;
  logic                   wbs_ack_o;
  logic [31:0]            wbs_dat_o;

  logic [BANKS-1:0]       sram_csb_n;
  logic                   sram_web_n;
  logic [3:0]             sram_wmask;
  logic [8:0]             sram_addr;
  logic [31:0]            sram_din;
  logic [32*BANKS-1:0]    sram_dout;

  modport slave (
    input  core_ce_n, core_we_n, core_wm, core_addr, core_wdata,
    output core_rdata, core_stall,
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output sram_csb_n, sram_web_n, sram_wmask, sram_addr, sram_din,
    input  sram_dout
  );

  modport master (
    output core_ce_n, core_we_n, core_wm, core_addr, core_wdata,
    input  core_rdata, core_stall,
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  sram_csb_n, sram_web_n, sram_wmask, sram_addr, sram_din,
    output sram_dout
  );
endinterface

// File: rtl/dmem_wb_arbiter.sv
// Shares banked single-port data SRAMs between the core and a Wishbone slave; the core has
// priority, but a Wishbone access that waits MAX_WAIT cycles forces a one-cycle core stall.
module dmem_wb_arbiter #(
  parameter int          BANKS    = 2,
  parameter logic [31:0] WB_BASE  = 32'h3000_0000,
  parameter int          MAX_WAIT = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  dmem_wb_arbiter_if.slave     bus,
  output logic [1:0]           dbg_state
);
  localparam int BW = $clog2(BANKS);
  localparam int AW = 9 + BW;
  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2,
    ACK    = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   wait_cnt;
  logic [BW-1:0]   core_bank_q;
  logic [BW-1:0]   wb_bank_q;

  logic [31:0]     wb_off;
  logic            wb_in_win;
  logic [8:0]      wb_word;
  logic [BW-1:0]   wb_bank;
  logic [BW-1:0]   core_bank;
  logic            wb_req;
  logic            wb_grant;
  logic            core_go;

  assign wb_off    = bus.wbs_adr_i - WB_BASE;
  assign wb_in_win = wb_off < 32'(BANKS * 2048);
  assign wb_word   = wb_off[10:2];
  assign wb_bank   = wb_off[BW+10:11];
  assign core_bank = bus.core_addr[AW-1:9];
  assign wb_req    = bus.wbs_cyc_i & bus.wbs_stb_i;
  // A stalled core request is dropped, so the stall cycle always belongs to Wishbone.
  assign wb_grant  = (state == ISSUE) && wb_req && (bus.core_ce_n || bus.core_stall);
  assign core_go   = !bus.core_ce_n && !bus.core_stall;

  assign bus.core_rdata = bus.sram_dout[{core_bank_q, 5'd0} +: 32];
  assign dbg_state      = state;

  always_comb begin
    bus.sram_csb_n = '1;
    bus.sram_web_n = 1'b1;
    bus.sram_wmask = 4'hF;
    bus.sram_addr  = '0;
    bus.sram_din   = '0;
    if (wb_grant) begin
      bus.sram_csb_n[wb_bank] = 1'b0;
      bus.sram_web_n          = !bus.wbs_we_i;
      bus.sram_wmask          = bus.wbs_we_i ? bus.wbs_sel_i : 4'hF;
      bus.sram_addr           = wb_word;
      bus.sram_din            = bus.wbs_dat_i;
    end else begin
      bus.sram_csb_n[core_bank] = !core_go;
      bus.sram_web_n            = bus.core_we_n;
      bus.sram_wmask            = bus.core_wm;
      bus.sram_addr             = bus.core_addr[8:0];
      bus.sram_din              = bus.core_wdata;
    end
    if (!wb_rst_ni) bus.sram_csb_n = '1;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      core_bank_q    <= '0;
      wb_bank_q      <= '0;
      bus.core_stall <= 1'b0;
      bus.wbs_ack_o  <= 1'b0;
      bus.wbs_dat_o  <= '0;
    end else begin
      bus.core_stall <= 1'b0;
      bus.wbs_ack_o  <= 1'b0;
      if (core_go) core_bank_q <= core_bank;
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (wb_req) begin
            if (wb_in_win) begin
              state <= ISSUE;
            end else begin
              bus.wbs_dat_o <= '0;
              bus.wbs_ack_o <= 1'b1;
              state         <= ACK;
            end
          end
        end
        ISSUE: begin
          if (!bus.wbs_cyc_i) begin
            wait_cnt <= '0;
            state    <= IDLE;
          end else if (wb_grant) begin
            wait_cnt  <= '0;
            wb_bank_q <= wb_bank;
            if (bus.wbs_we_i) begin
              bus.wbs_ack_o <= 1'b1;
              state         <= ACK;
            end else begin
              state <= RDWAIT;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == CW'(MAX_WAIT - 1)) bus.core_stall <= 1'b1;
          end
        end
        RDWAIT: begin
          if (!bus.wbs_cyc_i) begin
            state <= IDLE;
          end else begin
            bus.wbs_dat_o <= bus.sram_dout[{wb_bank_q, 5'd0} +: 32];
            bus.wbs_ack_o <= 1'b1;
            state         <= ACK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
